// File: rtl/conbus_arb_rr_wd.sv
// conbus_arb_rr_wd
// Round-robin cycle-level arbiter with a bus watchdog for the shared Wishbone conbus.
// The arbiter holds a grant for the whole CYC of the owning master. If the owner's STB
// is never ACKed, the transfer is killed with a one-cycle ERR, and the abort level is
// then held until the owner drops CYC. A dead slave therefore cannot hang the bus.
//
// Ports
//   sys_clk    in   system clock, all logic on the rising edge
//   sys_rst    in   synchronous active-high reset
//   req        in   per-master CYC, NMASTERS bits
//   bus_stb    in   STB of the shared (muxed) bus
//   bus_ack    in   OR of all slave ACKs
//   gnt        out  index of the master owning the shared bus
//   gnt_valid  out  a master currently owns the bus
//   abort      out  ACK to the owner is masked because the transfer was killed
//   err_o      out  one-cycle ERR pulse to the owner on timeout
//   wd_clr     in   clears wd_count and wd_master
//   wd_count   out  saturating count of timeouts since reset/clear
//   wd_master  out  owner index at the most recent timeout
module conbus_arb_rr_wd #(
    parameter int NMASTERS = 4,
    parameter int TIMEOUT  = 255,
    localparam int GW      = (NMASTERS > 1) ? $clog2(NMASTERS) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NMASTERS-1:0] req,
    input  logic                bus_stb,
    input  logic                bus_ack,
    output logic [GW-1:0]       gnt,
    output logic                gnt_valid,
    output logic                abort,
    output logic                err_o,
    input  logic                wd_clr,
    output logic [7:0]          wd_count,
    output logic [GW-1:0]       wd_master
);

    localparam bit       WD_EN    = (TIMEOUT != 0);
    localparam logic [7:0] WD_LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t        state_q;
    logic [GW-1:0] gnt_q;
    logic          gnt_valid_q;
    logic          abort_q;
    logic          err_q;
    logic [GW-1:0] ptr_q;
    logic [7:0]    wdog_q;
    logic [7:0]    wd_count_q;
    logic [GW-1:0] wd_master_q;

    logic [GW-1:0] gnt_idle_d;
    logic [GW-1:0] gnt_hand_d;
    logic [GW-1:0] ptr_d;
    logic          owner_req_s;
    logic          release_s;
    logic          stall_s;
    logic          timeout_s;

    // Index one past g, wrapping at NMASTERS (works for non-power-of-two counts).
    function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] g);
        logic [GW:0] sum;
        sum = {1'b0, g} + (GW+1)'(1);
        if (sum >= (GW+1)'(NMASTERS)) begin
            sum = '0;
        end else begin
            sum = sum;
        end
        return sum[GW-1:0];
    endfunction

    // First set bit of r scanning start, start+1, ... modulo NMASTERS.
    function automatic logic [GW-1:0] rr_search(input logic [NMASTERS-1:0] r,
                                                input logic [GW-1:0]       start);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        logic [GW:0]   sum;
        logic          found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NMASTERS; i++) begin
            sum = {1'b0, start} + (GW+1)'(i);
            if (sum >= (GW+1)'(NMASTERS)) begin
                sum = sum - (GW+1)'(NMASTERS);
            end else begin
                sum = sum;
            end
            idx = sum[GW-1:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Arbitration candidates and watchdog trip condition for the current cycle.
    always_comb begin
        ptr_d       = inc_mod(gnt_q);
        gnt_idle_d  = rr_search(req, ptr_q);
        gnt_hand_d  = rr_search(req, ptr_d);
        owner_req_s = req[gnt_q];
        release_s   = ((state_q == ST_OWN) || (state_q == ST_ABORT)) && !owner_req_s;
        stall_s     = bus_stb && !bus_ack;
        // ACK in the limit cycle clears stall_s, so ACK wins over the timeout.
        timeout_s   = WD_EN && (state_q == ST_OWN) && owner_req_s && stall_s
                      && (wdog_q == WD_LIMIT);
    end

    // Arbiter FSM, watchdog counter and timeout statistics.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            wdog_q      <= 8'd0;
            wd_count_q  <= 8'd0;
            wd_master_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (release_s) begin
                // Handover: the next owner is searched from gnt+1 on the same edge.
                ptr_q   <= ptr_d;
                abort_q <= 1'b0;
                wdog_q  <= 8'd0;
                if (|req) begin
                    gnt_q       <= gnt_hand_d;
                    gnt_valid_q <= 1'b1;
                    state_q     <= ST_OWN;
                end else begin
                    gnt_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (|req) begin
                            gnt_q       <= gnt_idle_d;
                            gnt_valid_q <= 1'b1;
                            state_q     <= ST_OWN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_OWN: begin
                        if (timeout_s) begin
                            err_q   <= 1'b1;
                            abort_q <= 1'b1;
                            wdog_q  <= 8'd0;
                            state_q <= ST_ABORT;
                        end else if (stall_s) begin
                            wdog_q <= (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
                        end else begin
                            wdog_q <= 8'd0;
                        end
                    end
                    ST_ABORT: begin
                        // Late ACKs are ignored; wait for the owner to drop CYC.
                        state_q <= ST_ABORT;
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        gnt_valid_q <= 1'b0;
                        abort_q     <= 1'b0;
                        wdog_q      <= 8'd0;
                    end
                endcase
            end

            // A timeout in the same cycle as wd_clr counts as the first event after clear.
            if (timeout_s) begin
                wd_count_q  <= wd_clr ? 8'd1
                             : ((wd_count_q == 8'hFF) ? wd_count_q : wd_count_q + 8'd1);
                wd_master_q <= gnt_q;
            end else if (wd_clr) begin
                wd_count_q  <= 8'd0;
                wd_master_q <= '0;
            end else begin
                wd_count_q  <= wd_count_q;
                wd_master_q <= wd_master_q;
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign abort     = abort_q;
    assign err_o     = err_q;
    assign wd_count  = wd_count_q;
    assign wd_master = wd_master_q;

endmodule
